pwm_capture: RTL and testbench

Measures an incoming servo-style PWM signal and reports the high-time and period of each full cycle, both in clock cycles. It is the receive-side counterpart of the team's servo PWM generator. Typical sources are an RC receiver channel or a loop-back of our own generator output. It runs in the 30 MHz fabric domain and feeds control logic through a one-cycle sample strobe, a range flag and a loss-of-signal flag.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/sync_edge_detect.sv | 30 +++
 rtl/pwm_capture.sv | 137 +++++++++++++
 tb/tb_pwm_capture.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants for the servo PWM generator and capture blocks
package pwm_pkg;

    // Fabric clock and nominal servo frame (all timings in clk_30MHz cycles)
    localparam int CLK_FREQ       = 30_000_000;
    localparam int PWM_PERIOD_CLK = 600_000;   // 20 ms frame
    localparam int PULSE_0_DEG    = 30_000;    // 1.0 ms
    localparam int PULSE_180_DEG  = 60_000;    // 2.0 ms

    // Capture defaults
    localparam int CAP_CNT_W          = 20;
    localparam int CAP_PERIOD_MAX_CLK = 660_000;  // 22 ms timeout / longest reportable period
    localparam int CAP_PULSE_MIN_CLK  = 27_000;   // 0.9 ms
    localparam int CAP_PULSE_MAX_CLK  = 63_000;   // 2.1 ms

    // Capture FSM encodings
    localparam logic [1:0] ST_WAIT_RISE = 2'd0;
    localparam logic [1:0] ST_HIGH      = 2'd1;
    localparam logic [1:0] ST_LOW       = 2'd2;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - 2-FF synchronizer with delay flop and rise/fall strobes
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, s3_q;

    // s1/s2 resolve metastability, s3 holds the previous synchronized level
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;
    assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures high-time and period of each servo PWM cycle
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W          = CAP_CNT_W,
    parameter int PERIOD_MAX_CLK = CAP_PERIOD_MAX_CLK,
    parameter int PULSE_MIN_CLK  = CAP_PULSE_MIN_CLK,
    parameter int PULSE_MAX_CLK  = CAP_PULSE_MAX_CLK
) (
    input  logic             clk_30MHz,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] pulse_width,
    output logic [CNT_W-1:0] period,
    output logic             sample_valid,
    output logic             in_range,
    output logic             signal_lost
);

    localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);
    localparam logic [CNT_W-1:0] PERIOD_MAX_C = CNT_W'(PERIOD_MAX_CLK);
    localparam logic [CNT_W-1:0] PULSE_MIN_C  = CNT_W'(PULSE_MIN_CLK);
    localparam logic [CNT_W-1:0] PULSE_MAX_C  = CNT_W'(PULSE_MAX_CLK);

    logic pwm_level, pwm_rise, pwm_fall;

    sync_edge_detect u_sync (
        .clk_i   (clk_30MHz),
        .rst_n_i (rst_n),
        .async_i (pwm_in),
        .level_o (pwm_level),
        .rise_o  (pwm_rise),
        .fall_o  (pwm_fall)
    );

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_period_q, cnt_period_d;
    logic [CNT_W-1:0] cnt_high_q, cnt_high_d;
    logic [CNT_W-1:0] pulse_width_q, pulse_width_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             sample_valid_q, sample_valid_d;
    logic             in_range_q, in_range_d;
    logic             signal_lost_q, signal_lost_d;
    logic             timeout;

    // cnt_period only advances below the limit, so reaching it means the frame is too long
    assign timeout = (cnt_period_q == PERIOD_MAX_C);

    // Next-state logic: measurement FSM, counters and sample publication
    always_comb begin
        state_d        = state_q;
        cnt_period_d   = cnt_period_q;
        cnt_high_d     = cnt_high_q;
        pulse_width_d  = pulse_width_q;
        period_d       = period_q;
        in_range_d     = in_range_q;
        signal_lost_d  = signal_lost_q;
        sample_valid_d = 1'b0;

        case (state_q)
            ST_WAIT_RISE: begin
                // First edge after reset or loss: start measuring, nothing to report yet
                if (pwm_rise) begin
                    state_d      = ST_HIGH;
                    cnt_period_d = ONE_C;
                    cnt_high_d   = ONE_C;
                end
            end
            ST_HIGH: begin
                // A rise cannot occur here (a fall must come first), so only timeout matters
                if (timeout) begin
                    state_d       = ST_WAIT_RISE;
                    signal_lost_d = 1'b1;
                end else begin
                    cnt_period_d = cnt_period_q + ONE_C;
                    if (pwm_level) begin
                        cnt_high_d = cnt_high_q + ONE_C;
                    end
                    if (pwm_fall) begin
                        state_d = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                // Rise beats timeout, so a frame of exactly PERIOD_MAX_CLK is still reported
                if (pwm_rise) begin
                    pulse_width_d  = cnt_high_q;
                    period_d       = cnt_period_q;
                    in_range_d     = (cnt_high_q >= PULSE_MIN_C) && (cnt_high_q <= PULSE_MAX_C);
                    sample_valid_d = 1'b1;
                    signal_lost_d  = 1'b0;
                    cnt_period_d   = ONE_C;
                    cnt_high_d     = ONE_C;
                    state_d        = ST_HIGH;
                end else if (timeout) begin
                    state_d       = ST_WAIT_RISE;
                    signal_lost_d = 1'b1;
                end else begin
                    cnt_period_d = cnt_period_q + ONE_C;
                end
            end
            default: begin
                state_d = ST_WAIT_RISE;
            end
        endcase
    end

    // State and output registers; reset discards any partial measurement
    always_ff @(posedge clk_30MHz) begin
        if (!rst_n) begin
            state_q        <= ST_WAIT_RISE;
            cnt_period_q   <= '0;
            cnt_high_q     <= '0;
            pulse_width_q  <= '0;
            period_q       <= '0;
            sample_valid_q <= 1'b0;
            in_range_q     <= 1'b0;
            signal_lost_q  <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_period_q   <= cnt_period_d;
            cnt_high_q     <= cnt_high_d;
            pulse_width_q  <= pulse_width_d;
            period_q       <= period_d;
            sample_valid_q <= sample_valid_d;
            in_range_q     <= in_range_d;
            signal_lost_q  <= signal_lost_d;
        end
    end

    assign pulse_width  = pulse_width_q;
    assign period       = period_q;
    assign sample_valid = sample_valid_q;
    assign in_range     = in_range_q;
    assign signal_lost  = signal_lost_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture with scaled-down timing
module tb_pwm_capture;

    localparam int CNT_W = 20;
    localparam int PMAX  = 660;   // timeout, scaled 1/1000
    localparam int WMIN  = 27;
    localparam int WMAX  = 63;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] pulse_width, period;
    logic             sample_valid, in_range, signal_lost;

    pwm_capture #(
        .CNT_W          (CNT_W),
        .PERIOD_MAX_CLK (PMAX),
        .PULSE_MIN_CLK  (WMIN),
        .PULSE_MAX_CLK  (WMAX)
    ) dut (
        .clk_30MHz    (clk),
        .rst_n        (rst_n),
        .pwm_in       (pwm_in),
        .pulse_width  (pulse_width),
        .period       (period),
        .sample_valid (sample_valid),
        .in_range     (in_range),
        .signal_lost  (signal_lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int pw;
        int per;
        bit rng;
        int cyc;
    } samp_t;

    samp_t sq[$];
    int    tq[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // reference model state: what the line has done since the last reset/loss
    bit have_prev = 1'b0;
    bit lost      = 1'b1;
    int prev_w    = 0;
    int prev_p    = 0;

    function automatic void check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // A rise driven at cycle t is seen by the capture block three edges later.
    function automatic void model_rise(int t, int w, int p, bit rst_mid);
        if (have_prev) begin
            sq.push_back('{prev_w, prev_p, (prev_w >= WMIN && prev_w <= WMAX), t + 3});
            lost = 1'b0;
        end
        if (p > PMAX) begin
            if (!lost) tq.push_back(t + 3 + PMAX);
            lost      = 1'b1;
            have_prev = 1'b0;
        end else begin
            have_prev = 1'b1;
        end
        if (rst_mid) begin
            lost      = 1'b1;
            have_prev = 1'b0;
        end
        prev_w = w;
        prev_p = p;
    endfunction

    // One PWM frame: w cycles high then p-w cycles low; optional reset right at the falling edge
    task automatic seg(input int w, input int p, input bit rst_mid = 1'b0);
        int t;
        @(negedge clk);
        t = cyc;
        model_rise(t, w, p, rst_mid);
        for (int i = 0; i < p; i++) begin
            if (i > 0) @(negedge clk);
            pwm_in = (i < w);
            if (rst_mid && i == w) rst_n = 1'b0;
            if (rst_mid && i == w + 1) begin
                check("rst_mid pulse_width", pulse_width, 0);
                check("rst_mid period", period, 0);
                check("rst_mid sample_valid", sample_valid, 0);
                check("rst_mid in_range", in_range, 0);
                check("rst_mid signal_lost", signal_lost, 1);
                rst_n = 1'b1;
            end
        end
    endtask

    // Monitor: compares every strobe and every loss event against the scoreboard
    initial begin
        bit    prev_lost;
        samp_t s;
        int    tc;
        prev_lost = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                prev_lost = signal_lost;
            end else begin
                if (sample_valid) begin
                    if (sq.size() == 0) begin
                        check("unexpected sample_valid", 1, 0);
                    end else begin
                        s = sq.pop_front();
                        check("sample cycle", cyc, s.cyc);
                        check("pulse_width", pulse_width, s.pw);
                        check("period", period, s.per);
                        check("in_range", in_range, s.rng);
                        check("signal_lost on sample", signal_lost, 0);
                    end
                end
                if (signal_lost && !prev_lost) begin
                    if (tq.size() == 0) begin
                        check("unexpected signal_lost", 1, 0);
                    end else begin
                        tc = tq.pop_front();
                        check("signal_lost cycle", cyc, tc);
                    end
                end
                prev_lost = signal_lost;
            end
        end
    end

    initial begin
        int w, p;
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset pulse_width", pulse_width, 0);
        check("reset period", period, 0);
        check("reset sample_valid", sample_valid, 0);
        check("reset in_range", in_range, 0);
        check("reset signal_lost", signal_lost, 1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // nominal 1.5 ms / 20 ms
        repeat (4) seg(45, 600);
        // in-range bounds
        seg(WMIN, 600);
        seg(WMAX, 600);
        seg(WMIN - 1, 600);
        seg(WMAX + 1, 600);
        seg(45, 600);
        // loss while low, then recovery
        seg(45, PMAX + 240);
        repeat (3) seg(45, 600);
        // stuck high past the timeout
        seg(PMAX + 140, PMAX + 145);
        repeat (2) seg(45, 600);
        // rise exactly on the timeout cycle, then one cycle too late
        seg(45, PMAX);
        seg(45, PMAX + 1);
        repeat (2) seg(50, 600);
        // reset while the capture FSM is in HIGH
        seg(45, 600);
        seg(45, 600, 1'b1);
        repeat (3) seg(45, 600);
        // single-cycle glitch frame
        seg(1, 600);
        seg(45, 600);
        // randomized frames, occasionally past the timeout
        for (int k = 0; k < 16; k++) begin
            p = $urandom_range(100, 720);
            w = $urandom_range(1, 120);
            seg(w, p);
        end
        seg(45, 600);
        seg(45, 600);
        repeat (10) @(negedge clk);

        check("samples outstanding", sq.size(), 0);
        check("loss events outstanding", tq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
